// File: rtl/spi_frame_scheduler.sv
// -----------------------------------------------------------------------------
// spi_frame_scheduler
//
// Buffers 16-bit trace words and hands them to the SPI trace transmitter one
// complete frame at a time. The transmitter is told that a frame holds real
// data only once FRAME_WORDS words are buffered. Each word-pull (tx_free)
// advances a speculative read pointer. The committed frame base moves only
// when the whole frame has gone out. A host frame-reset therefore rewinds to
// the committed base, and the same frame is sent again.
//
// Optional build macro:
//   SPI_SCHED_STATS_EN  - when defined, builds the frames_sent (wrapping) and
//                         rollbacks (saturating) counters. When undefined,
//                         both outputs are tied to zero.
//
// Ports:
//   clk              system clock
//   rst              synchronous, active-high reset
//   in_word          trace word to buffer
//   in_valid         in_word valid
//   in_ready         buffer can accept; a word is written on in_valid && in_ready
//   spi_transmit     a complete frame is available, or a frame is in flight
//   spi_tx_word      buffered word at the read pointer (registered)
//   spi_tx_free      transmitter word-pull (dClk domain, asynchronous)
//   spi_frame_reset  host frame reset (dClk domain, asynchronous)
//   busy             a frame is in flight
//   fill_words       words held, counted from the committed frame base
//   frames_sent      committed-frame count
//   rollbacks        rollback count
//
// dClk must run at clk/4 or slower so that every pulse survives the
// synchroniser and is seen as a separate edge.
// -----------------------------------------------------------------------------
module spi_frame_scheduler #(
    parameter int FRAME_WORDS  = 8,
    parameter int DEPTH_FRAMES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [15:0]                                   in_word,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic                                          spi_transmit,
    output logic [15:0]                                   spi_tx_word,
    input  logic                                          spi_tx_free,
    input  logic                                          spi_frame_reset,
    output logic                                          busy,
    output logic [$clog2(FRAME_WORDS*DEPTH_FRAMES):0]     fill_words,
    output logic [15:0]                                   frames_sent,
    output logic [7:0]                                    rollbacks
);

    localparam int DEPTH = FRAME_WORDS * DEPTH_FRAMES;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;                  // pointer width incl. wrap bit
    localparam int WC_W  = $clog2(FRAME_WORDS + 1);

    localparam logic [PW-1:0]   DEPTH_P    = PW'(DEPTH);
    localparam logic [PW-1:0]   FRAME_P    = PW'(FRAME_WORDS);
    localparam logic [WC_W-1:0] FRAME_WC   = WC_W'(FRAME_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // dClk -> clk synchronisers with rising-edge detect.
    // Index 0 carries tx_free, index 1 carries frame_reset.
    // -------------------------------------------------------------------------
    logic [1:0] async_in;
    logic [1:0] event_pulse;
    logic       take_ev;
    logic       rb_ev;

    assign async_in = {spi_frame_reset, spi_tx_free};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg <= '0;
                    prev_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in[gi]};
                    prev_reg <= sync_reg[SYNC_STAGES-1];
                end
            end

            // Only the rising edge is an event; a held level does not repeat.
            assign event_pulse[gi] = sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    endgenerate

    assign take_ev = event_pulse[0];
    assign rb_ev   = event_pulse[1];

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   rd_ptr_next;
    logic [PW-1:0]   rd_ptr_inc;
    logic [PW-1:0]   rd_base_reg;
    logic [PW-1:0]   rd_base_next;
    logic [WC_W-1:0] wcnt_reg;
    logic [WC_W-1:0] wcnt_next;
    logic [WC_W-1:0] wcnt_inc;
    state_t          state_reg;
    state_t          state_next;
    logic            commit;
    logic            rollback;
    logic            wr_en;
    logic            has_frame;

    // Occupancy counts from the committed base, so words of an in-flight
    // frame still count as held and the space they use is not freed.
    assign fill_words   = wr_ptr_reg - rd_base_reg;
    assign in_ready     = (fill_words != DEPTH_P);
    assign wr_en        = in_valid && in_ready;
    assign has_frame    = (fill_words >= FRAME_P);
    assign busy         = (state_reg == SEND);
    assign spi_transmit = (state_reg == SEND) || has_frame;

    // -------------------------------------------------------------------------
    // Frame FSM: next-state and pointer updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        rd_ptr_next  = rd_ptr_reg;
        rd_base_next = rd_base_reg;
        wcnt_next    = wcnt_reg;
        commit       = 1'b0;
        rollback     = 1'b0;
        rd_ptr_inc   = rd_ptr_reg + PW'(1);
        // wcnt is always zero in IDLE, so this is also the count after the
        // first pull of a frame.
        wcnt_inc     = wcnt_reg + WC_W'(1);

        case (state_reg)
            IDLE: begin
                if (rb_ev) begin
                    // Nothing in flight: rewinding to the base changes nothing.
                    rd_ptr_next = rd_base_reg;
                end else if (take_ev && has_frame) begin
                    rd_ptr_next = rd_ptr_inc;
                    if (wcnt_inc == FRAME_WC) begin
                        rd_base_next = rd_ptr_inc;
                        wcnt_next    = '0;
                        commit       = 1'b1;
                    end else begin
                        wcnt_next  = wcnt_inc;
                        state_next = SEND;
                    end
                end
                // A pull with less than a full frame buffered is ignored.
            end

            SEND: begin
                if (rb_ev) begin
                    // Rollback beats a simultaneous pull, even the last one.
                    rd_ptr_next = rd_base_reg;
                    wcnt_next   = '0;
                    rollback    = 1'b1;
                    state_next  = IDLE;
                end else if (take_ev) begin
                    rd_ptr_next = rd_ptr_inc;
                    if (wcnt_inc == FRAME_WC) begin
                        // Last word has gone out: release the frame.
                        rd_base_next = rd_ptr_inc;
                        wcnt_next    = '0;
                        commit       = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        wcnt_next = wcnt_inc;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            rd_base_reg <= '0;
            wcnt_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            rd_ptr_reg  <= rd_ptr_next;
            rd_base_reg <= rd_base_next;
            wcnt_reg    <= wcnt_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word storage: simple dual-port RAM with a registered read port.
    // The read follows rd_ptr every cycle. The transmitter samples much later
    // than the one-cycle read latency.
    // -------------------------------------------------------------------------
    logic [15:0] mem [DEPTH];
    logic [15:0] tx_word_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_word_reg <= 16'h0000;
        end else begin
            tx_word_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    assign spi_tx_word = tx_word_reg;

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
`ifdef SPI_SCHED_STATS_EN
    logic [15:0] frames_sent_reg;
    logic [7:0]  rollbacks_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_sent_reg <= 16'h0000;
            rollbacks_reg   <= 8'h00;
        end else begin
            if (commit) begin
                frames_sent_reg <= frames_sent_reg + 16'd1;   // wraps
            end
            if (rollback && (rollbacks_reg != 8'hFF)) begin
                rollbacks_reg <= rollbacks_reg + 8'd1;        // saturates
            end
        end
    end

    assign frames_sent = frames_sent_reg;
    assign rollbacks   = rollbacks_reg;
`else
    logic stats_unused;

    // Without the counters, commit and rollback only steer the FSM.
    assign stats_unused = commit ^ rollback;
    assign frames_sent  = 16'h0000;
    assign rollbacks    = 8'h00;
`endif

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_scheduler
//
// Directed bench for spi_frame_scheduler. The reference is a queue of held
// words plus a small frame-progress record. A compare process checks every
// output against it whenever the design has settled after a stimulus step.
// Hand-computed literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_spi_frame_scheduler;

    localparam int FW    = 8;
    localparam int DEPTH = 32;
`ifdef SPI_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_word = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        spi_transmit;
    logic [15:0] spi_tx_word;
    logic        spi_tx_free = 1'b0;
    logic        spi_frame_reset = 1'b0;
    logic        busy;
    logic [5:0]  fill_words;
    logic [15:0] frames_sent;
    logic [7:0]  rollbacks;

    spi_frame_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .in_word         (in_word),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .spi_transmit    (spi_transmit),
        .spi_tx_word     (spi_tx_word),
        .spi_tx_free     (spi_tx_free),
        .spi_frame_reset (spi_frame_reset),
        .busy            (busy),
        .fill_words      (fill_words),
        .frames_sent     (frames_sent),
        .rollbacks       (rollbacks)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int q[$];          // words held from the committed base onwards
    bit m_send   = 1'b0;
    int m_taken  = 0;  // words pulled from the current frame
    int m_frames = 0;
    int m_rb     = 0;
    bit m_settled = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_clear();
        q.delete();
        m_send   = 1'b0;
        m_taken  = 0;
        m_frames = 0;
        m_rb     = 0;
    endtask

    task automatic m_take();
        if (!m_send) begin
            if (q.size() >= FW) begin
                m_send  = 1'b1;
                m_taken = 1;
            end
        end else begin
            m_taken++;
        end
        if (m_send && m_taken == FW) begin
            for (int i = 0; i < FW; i++) q.delete(0);
            m_send   = 1'b0;
            m_taken  = 0;
            m_frames = (m_frames + 1) % 65536;
        end
    endtask

    task automatic m_rollback();
        if (m_send && m_rb < 255) m_rb++;
        m_send  = 1'b0;
        m_taken = 0;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_settled) begin
            chk("model_fill_words", 32'(fill_words), 32'(q.size()));
            chk("model_in_ready", 32'(in_ready), (q.size() != DEPTH) ? 32'd1 : 32'd0);
            chk("model_busy", 32'(busy), 32'(m_send));
            chk("model_spi_transmit", 32'(spi_transmit),
                (m_send || q.size() >= FW) ? 32'd1 : 32'd0);
            chk("model_frames_sent", 32'(frames_sent), (STATS != 0) ? 32'(m_frames) : 32'd0);
            chk("model_rollbacks", 32'(rollbacks), (STATS != 0) ? 32'(m_rb) : 32'd0);
            if (m_taken < q.size())
                chk("model_spi_tx_word", 32'(spi_tx_word), 32'(q[m_taken]));
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
        m_settled = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        m_settled = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        spi_tx_free = 1'b0;
        spi_frame_reset = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rst_transmit"}, 32'(spi_transmit), 32'd0);
        chk({tag, "_rst_tx_word"}, 32'(spi_tx_word), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rst_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_rst_fill"}, 32'(fill_words), 32'd0);
        chk({tag, "_rst_frames"}, 32'(frames_sent), 32'd0);
        chk({tag, "_rst_rollbacks"}, 32'(rollbacks), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        settle();
    endtask

    // Back-to-back writes, one per clock; returns how many were accepted.
    task automatic write_words(input int base, input int n, output int accepted);
        logic acc;
        accepted = 0;
        m_settled = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_word  = 16'(base + i);
            in_valid = 1'b1;
            acc      = in_ready;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (acc) begin
                q.push_back(base + i);
                accepted++;
            end
        end
    endtask

    // One dClk-style pulse: 3 clk high, 4 clk low.
    task automatic pulse(input bit take, input bit rb);
        m_settled = 1'b0;
        @(negedge clk);
        spi_tx_free     = take;
        spi_frame_reset = rb;
        repeat (3) @(negedge clk);
        spi_tx_free     = 1'b0;
        spi_frame_reset = 1'b0;
        repeat (4) @(negedge clk);
        if (rb) m_rollback();
        else if (take) m_take();
    endtask

    task automatic pulse_settled(input bit take, input bit rb);
        pulse(take, rb);
        settle();
    endtask

    task automatic takes(input int n);
        for (int i = 0; i < n; i++) pulse_settled(1'b1, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        repeat (2) @(posedge clk);
        do_reset("init");

        // 1: one full frame out in order
        write_words(1, 7, acc);
        settle();
        chk("t1_transmit_before_8th", 32'(spi_transmit), 32'd0);
        write_words(8, 1, acc);
        chk("t1_transmit_after_8th", 32'(spi_transmit), 32'd1);
        settle();
        for (int k = 1; k <= 8; k++) begin
            chk("t1_word_order", 32'(spi_tx_word), 32'(k));
            pulse_settled(1'b1, 1'b0);
        end
        chk("t1_fill_end", 32'(fill_words), 32'd0);
        chk("t1_transmit_end", 32'(spi_transmit), 32'd0);
        chk("t1_frames_end", 32'(frames_sent), 32'(STATS));

        // 2: short buffer ignores pulls; rollback in IDLE is a no-op
        do_reset("t2");
        write_words(1, 7, acc);
        settle();
        pulse_settled(1'b1, 1'b0);
        chk("t2_transmit", 32'(spi_transmit), 32'd0);
        chk("t2_tx_word", 32'(spi_tx_word), 32'h0001);
        chk("t2_fill", 32'(fill_words), 32'd7);
        pulse_settled(1'b0, 1'b1);
        chk("t2_idle_rb_count", 32'(rollbacks), 32'd0);
        chk("t2_idle_rb_word", 32'(spi_tx_word), 32'h0001);

        // 3: rollback after 5 pulls, then resend whole frame
        do_reset("t3");
        write_words(1, 8, acc);
        settle();
        takes(5);
        chk("t3_mid_word", 32'(spi_tx_word), 32'h0006);
        pulse_settled(1'b0, 1'b1);
        chk("t3_rollbacks", 32'(rollbacks), 32'(STATS));
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_tx_word", 32'(spi_tx_word), 32'h0001);
        chk("t3_fill", 32'(fill_words), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            chk("t3_resend_order", 32'(spi_tx_word), 32'(k));
            pulse_settled(1'b1, 1'b0);
        end
        chk("t3_frames", 32'(frames_sent), 32'(STATS));

        // 4: fill to capacity, reject the 33rd, free a frame
        do_reset("t4");
        write_words(32'h100, 32, acc);
        settle();
        chk("t4_accepted_32", 32'(acc), 32'd32);
        chk("t4_in_ready_full", 32'(in_ready), 32'd0);
        chk("t4_fill_full", 32'(fill_words), 32'd32);
        write_words(32'h1FF, 1, acc);
        settle();
        chk("t4_33rd_accepted", 32'(acc), 32'd0);
        chk("t4_fill_after_33rd", 32'(fill_words), 32'd32);
        takes(8);
        chk("t4_in_ready_after", 32'(in_ready), 32'd1);
        chk("t4_fill_after", 32'(fill_words), 32'd24);
        chk("t4_next_word", 32'(spi_tx_word), 32'h0108);

        // 5: rollback and final pull together -> rollback wins
        do_reset("t5");
        write_words(1, 8, acc);
        settle();
        takes(7);
        chk("t5_last_word", 32'(spi_tx_word), 32'h0008);
        pulse_settled(1'b1, 1'b1);
        chk("t5_frames", 32'(frames_sent), 32'd0);
        chk("t5_fill", 32'(fill_words), 32'd8);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tx_word", 32'(spi_tx_word), 32'h0001);
        chk("t5_rollbacks", 32'(rollbacks), 32'(STATS));

        // 6: reset mid-frame (do_reset checks all reset values)
        do_reset("t6pre");
        write_words(32'h300, 16, acc);
        settle();
        takes(3);
        chk("t6_busy_before", 32'(busy), 32'd1);
        do_reset("t6");
        chk("t6_fill_after", 32'(fill_words), 32'd0);

        // 7: writes overlap the committing pull
        write_words(1, 8, acc);
        settle();
        takes(7);
        m_settled = 1'b0;
        fork
            pulse(1'b1, 1'b0);
            write_words(32'h200, 6, acc);
        join
        settle();
        chk("t7_fill", 32'(fill_words), 32'd6);
        chk("t7_frames", 32'(frames_sent), 32'(STATS));
        chk("t7_tx_word", 32'(spi_tx_word), 32'h0200);
        repeat (4) @(posedge clk);

        m_settled = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
